seq_detect_prog: RTL

Runtime-programmable serial bit-sequence detector. It is the parametrised successor of the fixed 8-bit pattern detector. Pattern, length, don't-care mask and overlap mode are loaded through a config port. It adds input qualification (din_valid), a registered match pulse and a saturating match counter. It sits on serial monitor and decode paths wherever a fixed-pattern detector was previously instanced.

---
 rtl/seq_detect_prog.sv | 85 ++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with don't-care mask,
// overlap control, registered one-cycle match pulse and saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] lenmask;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len_clamped;
  logic               hit;

  always_comb begin
    hist_next   = {hist[MAX_LEN-2:0], din};
    fill_next   = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
    len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    lenmask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenmask[i] = (LEN_W'(i) < len);
    end
    // A config write in the same cycle drops the data bit, so it can never hit.
    hit = din_valid && !cfg_we && (len != '0) && (fill_next >= len) &&
          (((hist_next ^ pattern) & mask & lenmask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= '0;
      mask    <= '1;
      len     <= '0;
      overlap <= 1'b1;
      match   <= 1'b0;
    end else if (cfg_we) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= cfg_pattern;
      mask    <= cfg_mask;
      len     <= len_clamped;
      overlap <= cfg_overlap;
      match   <= 1'b0;
    end else begin
      match <= hit;
      if (din_valid) begin
        hist <= hist_next;
        fill <= (hit && !overlap) ? '0 : fill_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && match_cnt != CNT_MAX) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
